// File: rtl/reg_shadow_tracker.sv
// reg_shadow_tracker
// Snoops the register-file write port and keeps a shadow copy of x0..x31.
// Once per frame it publishes a tear-free snapshot for the VGA debug view,
// and it maintains a per-register highlight age that drives changed_mask.
//
// Ports
//   clk           display pixel clock (sole clock)
//   reset         synchronous, active-high
//   wr_en         register-file write strobe
//   wr_addr       destination register index
//   wr_data       write data
//   frame_tick    1-cycle pulse at start of vertical blanking (publish point)
//   freeze        1 = hold published snapshot and ages; tracking continues
//   regs_out      published snapshot, unpacked [0:NREGS-1]
//   changed_mask  bit i = 1 while register i highlight age != 0
//   mask_any      OR-reduction of changed_mask
//
// Build option
//   REG_TRACK_VALUE_CHANGE_EN : when defined, a write marks its register for
//   highlighting only if the data differs from the current shadow value.
//   When undefined, every write to x1..x31 marks the register.

module reg_shadow_tracker #(
  parameter int XLEN        = 32,
  parameter int NREGS       = 32,
  parameter int HOLD_FRAMES = 30
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     wr_en,
  input  logic [$clog2(NREGS)-1:0] wr_addr,
  input  logic [XLEN-1:0]          wr_data,
  input  logic                     frame_tick,
  input  logic                     freeze,
  output logic [XLEN-1:0]          regs_out [0:NREGS-1],
  output logic [NREGS-1:0]         changed_mask,
  output logic                     mask_any
);

  localparam int AGE_W = $clog2(HOLD_FRAMES + 1);

  logic [XLEN-1:0]  shadow_q   [0:NREGS-1];
  logic [XLEN-1:0]  shadow_d   [0:NREGS-1];
  logic [XLEN-1:0]  regs_out_q [0:NREGS-1];
  logic [XLEN-1:0]  regs_out_d [0:NREGS-1];
  logic [AGE_W-1:0] age_q      [0:NREGS-1];
  logic [AGE_W-1:0] age_d      [0:NREGS-1];
  logic [NREGS-1:0] pending_q;
  logic [NREGS-1:0] pending_d;
  logic [NREGS-1:0] mask_q;
  logic [NREGS-1:0] mask_d;

  logic wr_hit;
  logic mark;
  logic publish;

  always_comb begin
    // x0 is hardwired to zero, so writes to it are ignored entirely.
    wr_hit = wr_en && (wr_addr != '0);
`ifdef REG_TRACK_VALUE_CHANGE_EN
    // Compare against the live shadow so a same-frame rewrite of an
    // already-changed value is judged against the latest write.
    mark = wr_hit && (wr_data != shadow_q[wr_addr]);
`else
    mark = wr_hit;
`endif
    publish = frame_tick && !freeze;
  end

  always_comb begin
    shadow_d   = shadow_q;
    regs_out_d = regs_out_q;
    age_d      = age_q;
    pending_d  = pending_q;
    mask_d     = mask_q;

    if (wr_hit) begin
      shadow_d[wr_addr] = wr_data;
    end

    if (publish) begin
      // Snapshot uses the pre-write shadow: a same-cycle write waits for
      // the next frame.
      regs_out_d = shadow_q;
      for (int i = 0; i < NREGS; i++) begin
        if (pending_q[i]) begin
          age_d[i] = AGE_W'(HOLD_FRAMES);
        end else if (age_q[i] != '0) begin
          age_d[i] = age_q[i] - AGE_W'(1);
        end
        mask_d[i] = (age_d[i] != '0);
      end
      pending_d = '0;
    end

    // Applied after the publish clear so a same-cycle write survives it.
    if (mark) begin
      pending_d[wr_addr] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      shadow_q   <= '{default: '0};
      regs_out_q <= '{default: '0};
      age_q      <= '{default: '0};
      pending_q  <= '0;
      mask_q     <= '0;
    end else begin
      shadow_q   <= shadow_d;
      regs_out_q <= regs_out_d;
      age_q      <= age_d;
      pending_q  <= pending_d;
      mask_q     <= mask_d;
    end
  end

  assign regs_out     = regs_out_q;
  assign changed_mask = mask_q;
  assign mask_any     = |mask_q;

endmodule

// File: tb/tb_reg_shadow_tracker.sv
// Directed testbench for reg_shadow_tracker (HOLD_FRAMES overridden to 4).

module tb_reg_shadow_tracker;

  localparam int XLEN  = 32;
  localparam int NREGS = 32;
  localparam int HOLD  = 4;

  logic            clk;
  logic            reset;
  logic            wr_en;
  logic [4:0]      wr_addr;
  logic [XLEN-1:0] wr_data;
  logic            frame_tick;
  logic            freeze;
  logic [XLEN-1:0] regs_out [0:NREGS-1];
  logic [31:0]     changed_mask;
  logic            mask_any;

  int n_cmp;
  int n_err;

  reg_shadow_tracker #(
    .XLEN(XLEN),
    .NREGS(NREGS),
    .HOLD_FRAMES(HOLD)
  ) dut (
    .clk(clk),
    .reset(reset),
    .wr_en(wr_en),
    .wr_addr(wr_addr),
    .wr_data(wr_data),
    .frame_tick(frame_tick),
    .freeze(freeze),
    .regs_out(regs_out),
    .changed_mask(changed_mask),
    .mask_any(mask_any)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // One clock with the given inputs; outputs are stable #1 after the edge.
  task automatic step(input logic ft, input logic we, input logic [4:0] a,
                      input logic [31:0] d);
    frame_tick = ft;
    wr_en      = we;
    wr_addr    = a;
    wr_data    = d;
    @(posedge clk);
    #1;
    frame_tick = 1'b0;
    wr_en      = 1'b0;
  endtask

  task automatic tick();
    step(1'b1, 1'b0, 5'd0, 32'h0);
  endtask

  function automatic logic [31:0] regs_or();
    logic [31:0] acc;
    acc = '0;
    for (int i = 0; i < NREGS; i++) acc |= regs_out[i];
    return acc;
  endfunction

  logic [31:0] exp_rewrite;

  initial begin
    n_cmp      = 0;
    n_err      = 0;
    reset      = 1'b1;
    wr_en      = 1'b0;
    wr_addr    = '0;
    wr_data    = '0;
    frame_tick = 1'b0;
    freeze     = 1'b0;

    // Reset: 2 cycles, then 3 ticks
    step(1'b0, 1'b0, 5'd0, 32'h0);
    step(1'b0, 1'b0, 5'd0, 32'h0);
    reset = 1'b0;
    check("rst_regs", regs_or(), 32'h0);
    check("rst_mask", changed_mask, 32'h0);
    for (int k = 0; k < 3; k++) tick();
    check("rst_regs_ticks", regs_or(), 32'h0);
    check("rst_mask_ticks", changed_mask, 32'h0);
    check("rst_any_ticks", {31'h0, mask_any}, 32'h0);

    // Basic write x5, then hold for exactly HOLD ticks
    step(1'b0, 1'b1, 5'd5, 32'hDEAD_BEEF);
    check("basic_pre_tick", regs_out[5], 32'h0);
    tick();
    check("basic_reg5", regs_out[5], 32'hDEAD_BEEF);
    check("basic_mask", changed_mask, 32'h0000_0020);
    check("basic_any", {31'h0, mask_any}, 32'h1);
    for (int k = 2; k <= HOLD; k++) begin
      tick();
      check("basic_hold", changed_mask, 32'h0000_0020);
    end
    tick();
    check("basic_expire", changed_mask, 32'h0);
    check("basic_expire_any", {31'h0, mask_any}, 32'h0);
    check("basic_reg5_kept", regs_out[5], 32'hDEAD_BEEF);

    // x0 drop and write coincident with frame_tick
    step(1'b0, 1'b1, 5'd0, 32'h1234);
    tick();
    check("x0_reg", regs_out[0], 32'h0);
    check("x0_mask", changed_mask, 32'h0);
    step(1'b1, 1'b1, 5'd7, 32'h55);
    check("same_cyc_reg7_old", regs_out[7], 32'h0);
    check("same_cyc_mask_old", changed_mask, 32'h0);
    tick();
    check("same_cyc_reg7_new", regs_out[7], 32'h55);
    check("same_cyc_mask_new", changed_mask, 32'h0000_0080);

    // Freeze: publish and ages hold, pending survives
    freeze = 1'b1;
    step(1'b0, 1'b1, 5'd10, 32'hA);
    tick();
    tick();
    check("frz_reg10", regs_out[10], 32'h0);
    check("frz_mask_held", changed_mask, 32'h0000_0080);
    freeze = 1'b0;
    tick();
    check("unfrz_reg10", regs_out[10], 32'hA);
    check("unfrz_mask10", {31'h0, changed_mask[10]}, 32'h1);
    check("unfrz_mask7_aged", {31'h0, changed_mask[7]}, 32'h1);

    // Same-value rewrite
    step(1'b0, 1'b1, 5'd3, 32'h7);
    tick();
    check("rw_first_reg3", regs_out[3], 32'h7);
    check("rw_first_mask3", {31'h0, changed_mask[3]}, 32'h1);
    for (int k = 0; k < HOLD; k++) tick();
    check("rw_aged_mask3", {31'h0, changed_mask[3]}, 32'h0);
    step(1'b0, 1'b1, 5'd3, 32'h7);
    tick();
`ifdef REG_TRACK_VALUE_CHANGE_EN
    exp_rewrite = 32'h0;
`else
    exp_rewrite = 32'h1;
`endif
    check("rw_same_mask3", {31'h0, changed_mask[3]}, exp_rewrite);
    check("rw_same_reg3", regs_out[3], 32'h7);

    // Re-marking: write x1 every 2 frames, never clears until HOLD after last
    for (int w = 0; w < 4; w++) begin
      step(1'b0, 1'b1, 5'd1, 32'(w + 1));
      tick();
      check("remark_load", {31'h0, changed_mask[1]}, 32'h1);
      tick();
      check("remark_mid", {31'h0, changed_mask[1]}, 32'h1);
    end
    check("remark_reg1", regs_out[1], 32'h4);
    tick();
    tick();
    check("remark_tail", {31'h0, changed_mask[1]}, 32'h1);
    tick();
    check("remark_clear", {31'h0, changed_mask[1]}, 32'h0);

    // Reset during freeze drops pending and all state
    freeze = 1'b1;
    step(1'b0, 1'b1, 5'd2, 32'h99);
    reset = 1'b1;
    step(1'b0, 1'b0, 5'd0, 32'h0);
    reset  = 1'b0;
    freeze = 1'b0;
    check("midrst_reg5", regs_out[5], 32'h0);
    tick();
    check("midrst_regs", regs_or(), 32'h0);
    check("midrst_mask", changed_mask, 32'h0);
    check("midrst_any", {31'h0, mask_any}, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
